// File: rtl/mux4_sel_arbiter.sv
// mux4_sel_arbiter: round-robin arbiter sharing one 4:1 W-bit select path among four requesters
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   req       level-sensitive request per requester
//   done      current grantee finished (only looked at while granted)
//   E0..E3    W-bit data from each requester
//   grant     registered one-hot grant
//   sel       index of current or last grantee
//   addr_out  data of the grantee, latched when the grant is issued
//   busy      high while a grant is held
//   timeout   one-cycle pulse when a tenure is cut off by the hold limit
module mux4_sel_arbiter #(
    parameter int W        = 5,
    parameter int HOLD_MAX = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic         done,
    input  logic [W-1:0] E0,
    input  logic [W-1:0] E1,
    input  logic [W-1:0] E2,
    input  logic [W-1:0] E3,
    output logic [3:0]   grant,
    output logic [1:0]   sel,
    output logic [W-1:0] addr_out,
    output logic         busy,
    output logic         timeout
);
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
    state_t       r_state;
    logic [7:0]   r_cnt;
    logic [1:0]   r_last;
    logic [1:0]   w_k;
    logic [W-1:0] w_data;
    logic         w_exit;
    // Scan from the furthest position back to the nearest so the nearest set bit after r_last wins.
    always_comb begin
        w_k = r_last;
        for (int i = 4; i >= 1; i--)
            if (req[r_last + 2'(i)]) w_k = r_last + 2'(i);
    end
    assign w_data = (w_k == 2'd0) ? E0 : (w_k == 2'd1) ? E1 : (w_k == 2'd2) ? E2 : E3;
    assign w_exit = done || !req[sel] || (r_cnt == 8'(HOLD_MAX - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_last   <= 2'd3;
            grant    <= '0;
            sel      <= '0;
            addr_out <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (r_state)
                IDLE: if (|req) begin
                    r_state  <= GRANT;
                    grant    <= 4'b0001 << w_k;
                    sel      <= w_k;
                    addr_out <= w_data;
                    busy     <= 1'b1;
                    r_last   <= w_k;
                    r_cnt    <= '0;
                end
                GRANT: if (w_exit) begin
                    r_state <= RELEASE;
                    grant   <= '0;
                    busy    <= 1'b0;
                    // Only the hold limit raises timeout; done and withdrawal take precedence.
                    timeout <= !done && req[sel];
                end else begin
                    r_cnt <= (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
